// File: rtl/rf_write_arbiter_if.sv
// Signal bundle between the WB stage, the mult/div result path and the register-file write port.
// The arbiter uses the slave modport; the requesters and the register file side use master.
interface rf_write_arbiter_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADR_W  = 5
);
    logic                    wbValid;
    logic [ADR_W-1:0]        wbAdr;
    logic [DATA_W-1:0]       wbData;
    logic                    stall;
    logic                    mdValid;
    logic [ADR_W-1:0]        mdAdr;
    logic [DATA_W-1:0]       mdData;
    logic                    mdReady;
    logic                    issueValid;
    logic [ADR_W-1:0]        issueAdr;
    logic                    regWrite;
    logic [ADR_W-1:0]        writeAdr;
    logic [DATA_W-1:0]       writeData;
    logic [(1<<ADR_W)-1:0]   busy;

    modport slave (
        input  wbValid, wbAdr, wbData, mdValid, mdAdr, mdData, issueValid, issueAdr,
        output stall, mdReady, regWrite, writeAdr, writeData, busy
    );

    modport master (
        output wbValid, wbAdr, wbData, mdValid, mdAdr, mdData, issueValid, issueAdr,
        input  stall, mdReady, regWrite, writeAdr, writeData, busy
    );
endinterface

// File: rtl/rf_write_arbiter.sv
// Arbitrates the single register-file write port between writeback (priority) and mult/div,
// with a starvation-forced B grant, a one-entry A hold buffer and a busy scoreboard.
module rf_write_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned ADR_W        = 5
) (
    input logic               clk,
    input logic               rst,
    rf_write_arbiter_if.slave bus
);
    localparam int unsigned NREG  = 1 << ADR_W;
    localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    logic              hold_valid_q, hold_valid_d;
    logic [ADR_W-1:0]  hold_adr_q, hold_adr_d;
    logic [DATA_W-1:0] hold_data_q, hold_data_d;
    logic [CNT_W-1:0]  wait_q, wait_d;
    logic [NREG-1:0]   busy_q, busy_d;

    logic              force_b;
    logic              sel_valid;
    logic [ADR_W-1:0]  sel_adr;
    logic [DATA_W-1:0] sel_data;
    logic              md_ready;

    assign force_b = bus.mdValid && (wait_q == LIMIT);

    always_comb begin
        sel_valid    = 1'b0;
        sel_adr      = '0;
        sel_data     = '0;
        md_ready     = 1'b0;
        hold_valid_d = hold_valid_q;
        hold_adr_d   = hold_adr_q;
        hold_data_d  = hold_data_q;
        if (hold_valid_q) begin
            sel_valid    = 1'b1;
            sel_adr      = hold_adr_q;
            sel_data     = hold_data_q;
            hold_valid_d = 1'b0;
        end else if (force_b) begin
            sel_valid = 1'b1;
            sel_adr   = bus.mdAdr;
            sel_data  = bus.mdData;
            md_ready  = 1'b1;
            // The displaced A write is accepted now and retired from the hold next cycle.
            if (bus.wbValid) begin
                hold_valid_d = 1'b1;
                hold_adr_d   = bus.wbAdr;
                hold_data_d  = bus.wbData;
            end
        end else if (bus.wbValid) begin
            sel_valid = 1'b1;
            sel_adr   = bus.wbAdr;
            sel_data  = bus.wbData;
        end else if (bus.mdValid) begin
            sel_valid = 1'b1;
            sel_adr   = bus.mdAdr;
            sel_data  = bus.mdData;
            md_ready  = 1'b1;
        end
    end

    always_comb begin
        wait_d = '0;
        if (bus.mdValid && !md_ready) begin
            wait_d = (wait_q == LIMIT) ? wait_q : wait_q + CNT_W'(1);
        end
    end

    // Set after clear so a same-cycle issue to the retiring register wins.
    always_comb begin
        busy_d = busy_q;
        if (bus.mdValid && md_ready) begin
            busy_d[bus.mdAdr] = 1'b0;
        end
        if (bus.issueValid) begin
            busy_d[bus.issueAdr] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hold_valid_q <= 1'b0;
            hold_adr_q   <= '0;
            hold_data_q  <= '0;
            wait_q       <= '0;
            busy_q       <= '0;
        end else begin
            hold_valid_q <= hold_valid_d;
            hold_adr_q   <= hold_adr_d;
            hold_data_q  <= hold_data_d;
            wait_q       <= wait_d;
            busy_q       <= busy_d;
        end
    end

    // Outputs are gated by reset so they drop without waiting for a clock edge.
    assign bus.regWrite  = rst && sel_valid && (sel_adr != '0);
    assign bus.writeAdr  = sel_adr;
    assign bus.writeData = sel_data;
    assign bus.mdReady   = rst && md_ready;
    assign bus.stall     = rst && hold_valid_q;
    assign bus.busy      = busy_q;
endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed self-checking bench for rf_write_arbiter: reset, A/B paths, starvation, r0, scoreboard.
module tb_rf_write_arbiter;
    logic clk;
    logic rst;
    int   checks;
    int   failures;

    rf_write_arbiter_if #(.DATA_W(32), .ADR_W(5)) bus ();

    rf_write_arbiter #(.STARVE_LIMIT(4), .DATA_W(32), .ADR_W(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.wbValid    = 1'b0;
        bus.wbAdr      = '0;
        bus.wbData     = '0;
        bus.mdValid    = 1'b0;
        bus.mdAdr      = '0;
        bus.mdData     = '0;
        bus.issueValid = 1'b0;
        bus.issueAdr   = '0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        idle_inputs();
        bus.wbValid = 1'b1;
        bus.wbAdr   = 5'd4;
        bus.mdValid = 1'b1;
        bus.mdAdr   = 5'd5;
        #12;
        checks++;
        if (bus.regWrite !== 1'b0 || bus.mdReady !== 1'b0 || bus.stall !== 1'b0) begin
            failures++;
            $display("FAIL reset_outputs: regWrite=%b mdReady=%b stall=%b, want 0 0 0",
                     bus.regWrite, bus.mdReady, bus.stall);
        end
        idle_inputs();
        @(negedge clk);
        rst = 1'b1;
        tick();
        @(negedge clk);
        checks++;
        if (bus.regWrite !== 1'b0 || bus.mdReady !== 1'b0 || bus.stall !== 1'b0 ||
            bus.busy !== 32'h0) begin
            failures++;
            $display("FAIL reset_idle: regWrite=%b mdReady=%b stall=%b busy=%h, want 0 0 0 0",
                     bus.regWrite, bus.mdReady, bus.stall, bus.busy);
        end
        tick();
    endtask

    task automatic test_a_only();
        bus.wbValid = 1'b1;
        bus.wbAdr   = 5'd3;
        bus.wbData  = 32'hDEAD_BEEF;
        @(negedge clk);
        checks++;
        if (bus.regWrite !== 1'b1 || bus.writeAdr !== 5'd3 || bus.writeData !== 32'hDEAD_BEEF ||
            bus.stall !== 1'b0 || bus.mdReady !== 1'b0) begin
            failures++;
            $display("FAIL a_only: regWrite=%b adr=%0d data=%h stall=%b mdReady=%b, want 1 3 deadbeef 0 0",
                     bus.regWrite, bus.writeAdr, bus.writeData, bus.stall, bus.mdReady);
        end
        tick();
        idle_inputs();
    endtask

    task automatic test_b_only();
        bus.issueValid = 1'b1;
        bus.issueAdr   = 5'd9;
        tick();
        idle_inputs();
        @(negedge clk);
        checks++;
        if (bus.busy !== 32'h0000_0200) begin
            failures++;
            $display("FAIL b_busy_set: busy=%h, want 00000200", bus.busy);
        end
        tick();
        bus.mdValid = 1'b1;
        bus.mdAdr   = 5'd9;
        bus.mdData  = 32'h1234;
        @(negedge clk);
        checks++;
        if (bus.mdReady !== 1'b1 || bus.regWrite !== 1'b1 || bus.writeAdr !== 5'd9 ||
            bus.writeData !== 32'h1234) begin
            failures++;
            $display("FAIL b_write: mdReady=%b regWrite=%b adr=%0d data=%h, want 1 1 9 00001234",
                     bus.mdReady, bus.regWrite, bus.writeAdr, bus.writeData);
        end
        tick();
        idle_inputs();
        @(negedge clk);
        checks++;
        if (bus.busy !== 32'h0) begin
            failures++;
            $display("FAIL b_busy_clear: busy=%h, want 00000000", bus.busy);
        end
        tick();
    endtask

    task automatic test_starvation();
        logic [4:0]  e_adr;
        logic [31:0] e_data;
        logic        e_stall;
        logic        e_rdy;
        for (int cyc = 1; cyc <= 7; cyc++) begin
            bus.wbValid = 1'b1;
            bus.wbAdr   = 5'((cyc <= 6) ? cyc : 6);
            bus.wbData  = 32'hA000_0000 + ((cyc <= 6) ? cyc : 6);
            bus.mdValid = (cyc <= 5);
            bus.mdAdr   = 5'd20;
            bus.mdData  = 32'hB0B0_B0B0;
            if (cyc <= 4) begin
                e_adr = 5'(cyc); e_data = 32'hA000_0000 + cyc; e_stall = 0; e_rdy = 0;
            end else if (cyc == 5) begin
                e_adr = 5'd20; e_data = 32'hB0B0_B0B0; e_stall = 0; e_rdy = 1;
            end else if (cyc == 6) begin
                e_adr = 5'd5; e_data = 32'hA000_0005; e_stall = 1; e_rdy = 0;
            end else begin
                e_adr = 5'd6; e_data = 32'hA000_0006; e_stall = 0; e_rdy = 0;
            end
            @(negedge clk);
            checks++;
            if (bus.regWrite !== 1'b1 || bus.writeAdr !== e_adr || bus.writeData !== e_data ||
                bus.stall !== e_stall || bus.mdReady !== e_rdy) begin
                failures++;
                $display("FAIL starve_c%0d: regWrite=%b adr=%0d data=%h stall=%b mdReady=%b, want 1 %0d %h %b %b",
                         cyc, bus.regWrite, bus.writeAdr, bus.writeData, bus.stall, bus.mdReady,
                         e_adr, e_data, e_stall, e_rdy);
            end
            tick();
        end
        idle_inputs();
        @(negedge clk);
        checks++;
        if (bus.regWrite !== 1'b0 || bus.stall !== 1'b0) begin
            failures++;
            $display("FAIL starve_drain: regWrite=%b stall=%b, want 0 0", bus.regWrite, bus.stall);
        end
        tick();
    endtask

    task automatic test_reset_mid_hold();
        bus.issueValid = 1'b1;
        bus.issueAdr   = 5'd12;
        tick();
        bus.issueValid = 1'b0;
        for (int cyc = 1; cyc <= 5; cyc++) begin
            bus.wbValid = 1'b1;
            bus.wbAdr   = 5'd10 + 5'(cyc);
            bus.wbData  = 32'hC000_0000 + cyc;
            bus.mdValid = 1'b1;
            bus.mdAdr   = 5'd25;
            bus.mdData  = 32'h5555;
            tick();
        end
        bus.mdValid = 1'b0;
        checks++;
        if (bus.stall !== 1'b1 || bus.regWrite !== 1'b1 || bus.busy !== 32'h0000_1000) begin
            failures++;
            $display("FAIL hold_setup: stall=%b regWrite=%b busy=%h, want 1 1 00001000",
                     bus.stall, bus.regWrite, bus.busy);
        end
        #1;
        rst = 1'b0;
        #1;
        checks++;
        if (bus.stall !== 1'b0 || bus.regWrite !== 1'b0 || bus.busy !== 32'h0 ||
            bus.mdReady !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_hold: stall=%b regWrite=%b busy=%h mdReady=%b, want 0 0 0 0",
                     bus.stall, bus.regWrite, bus.busy, bus.mdReady);
        end
        idle_inputs();
        @(negedge clk);
        rst = 1'b1;
        tick();
        @(negedge clk);
        checks++;
        if (bus.regWrite !== 1'b0 || bus.stall !== 1'b0) begin
            failures++;
            $display("FAIL hold_discarded: regWrite=%b stall=%b, want 0 0", bus.regWrite, bus.stall);
        end
        tick();
    endtask

    task automatic test_reg_zero();
        bus.wbValid = 1'b1;
        bus.wbAdr   = 5'd0;
        bus.wbData  = 32'h1111;
        @(negedge clk);
        checks++;
        if (bus.regWrite !== 1'b0 || bus.stall !== 1'b0) begin
            failures++;
            $display("FAIL r0_a: regWrite=%b stall=%b, want 0 0", bus.regWrite, bus.stall);
        end
        tick();
        idle_inputs();
        bus.mdValid    = 1'b1;
        bus.mdAdr      = 5'd0;
        bus.mdData     = 32'h2222;
        bus.issueValid = 1'b1;
        bus.issueAdr   = 5'd0;
        @(negedge clk);
        checks++;
        if (bus.mdReady !== 1'b1 || bus.regWrite !== 1'b0) begin
            failures++;
            $display("FAIL r0_b: mdReady=%b regWrite=%b, want 1 0", bus.mdReady, bus.regWrite);
        end
        tick();
        idle_inputs();
        bus.issueValid = 1'b1;
        bus.issueAdr   = 5'd0;
        tick();
        idle_inputs();
        @(negedge clk);
        checks++;
        if (bus.busy !== 32'h0) begin
            failures++;
            $display("FAIL r0_busy: busy=%h, want 00000000", bus.busy);
        end
        tick();
    endtask

    task automatic test_set_clear();
        bus.issueValid = 1'b1;
        bus.issueAdr   = 5'd7;
        tick();
        bus.mdValid = 1'b1;
        bus.mdAdr   = 5'd7;
        bus.mdData  = 32'h7777;
        @(negedge clk);
        checks++;
        if (bus.mdReady !== 1'b1 || bus.busy !== 32'h0000_0080) begin
            failures++;
            $display("FAIL setclr_pre: mdReady=%b busy=%h, want 1 00000080", bus.mdReady, bus.busy);
        end
        tick();
        idle_inputs();
        @(negedge clk);
        checks++;
        if (bus.busy !== 32'h0000_0080) begin
            failures++;
            $display("FAIL setclr_post: busy=%h, want 00000080", bus.busy);
        end
        tick();
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_a_only();
        test_b_only();
        test_starvation();
        test_reset_mid_hold();
        test_reg_zero();
        test_set_clear();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/rf_write_arbiter.md
Name: rf_write_arbiter

Overview:
- Shares the single register-file write port between two requesters.
  - Port A: the pipeline writeback stage. It has priority and cannot wait beyond a one-cycle stall.
  - Port B: the multi-cycle mult/div result path, using a valid/ready handshake.
- Sits between WB/mult-div and the register file; drives regWrite/writeAdr/writeData directly.
- Keeps a busy scoreboard of registers with outstanding multi-cycle results for the hazard unit.
- A starvation counter guarantees B progress; a one-entry hold buffer absorbs the displaced A write.

Parameters:
STARVE_LIMIT, 4, cycles B may wait with mdValid=1 before it is force-granted (>=1)
DATA_W, 32, write data width
ADR_W, 5, register address width (2**ADR_W registers)

Ports:
clk  input  1  clock, rising edge
rst  input  1  reset, asynchronous, active-low
wbValid  input  1  A write request
wbAdr  input  ADR_W  A destination register
wbData  input  DATA_W  A write data
stall  output  1  A not accepted this cycle; upstream holds wbValid/wbAdr/wbData
mdValid  input  1  B write request
mdAdr  input  ADR_W  B destination register
mdData  input  DATA_W  B write data
mdReady  output  1  B accepted this cycle (transfer = mdValid & mdReady)
issueValid  input  1  multi-cycle op issued
issueAdr  input  ADR_W  its destination register
regWrite  output  1  register-file write enable
writeAdr  output  ADR_W  register-file write address
writeData  output  DATA_W  register-file write data
busy  output  2**ADR_W  per-register outstanding-B flag

Behaviour:
- State:
  - holdValid/holdAdr/holdData: one-entry A buffer.
  - waitCnt: 0..STARVE_LIMIT, saturating.
  - busy vector.
- Reset (rst low, async):
  - holdValid=0, waitCnt=0, busy=0.
  - While rst low: regWrite=0, mdReady=0, stall=0.
- stall = holdValid.
- force = mdValid & (waitCnt==STARVE_LIMIT).
- Per-cycle grant, evaluated in this priority order; write outputs are combinational, with the write landing on the same clk edge:
  1. holdValid: write hold entry. mdReady=0. A not accepted (stall=1). holdValid clears next edge.
  2. force: write B, mdReady=1. If wbValid, capture wbAdr/wbData into hold and set holdValid next edge. That A write is accepted (stall=0 this cycle).
  3. wbValid: write A, mdReady=0.
  4. mdValid: write B, mdReady=1.
  5. Otherwise regWrite=0.
- waitCnt:
  - Increments (saturating) when mdValid & !mdReady.
  - Clears when mdValid & mdReady, or when mdValid=0.
- A is stalled for exactly one cycle per force event. It is never lost or reordered.
- Register 0:
  - A grant to address 0 drives regWrite=0. The handshake still completes: A accepted, mdReady=1 for B, hold drains.
  - busy[0] is always 0.
- Scoreboard:
  - issueValid sets busy[issueAdr].
  - A B transfer clears busy[mdAdr].
  - Set and clear on the same address in the same cycle: set wins.
  - Writes from A do not touch busy.
- B must hold mdAdr/mdData stable while mdValid=1 and mdReady=0.
- Reset mid-operation discards the hold entry, counter and busy bits. Outputs go inactive immediately, with no clk edge required.

Test Plan:
- Reset, then idle: regWrite=0, stall=0, mdReady=0, busy=0. Assert rst low mid-hold: holdValid, busy, regWrite clear immediately.
- A only: wbValid=1, wbAdr=3, wbData=0xDEADBEEF → same cycle regWrite=1, writeAdr=3, writeData=0xDEADBEEF, stall=0.
- B only, with scoreboard:
  - issueValid for adr 9 → busy[9]=1 next cycle.
  - mdValid, mdAdr=9, mdData=0x1234 with wbValid=0 → mdReady=1, write 9←0x1234, busy[9]=0 next cycle.
- Starvation, STARVE_LIMIT=4:
  - wbValid=1 continuously (adrs 1,2,3,…) with mdValid=1 → B waits 4 cycles, force-granted in cycle 5 (mdReady=1, B written).
  - The A write of cycle 5 is captured; cycle 6: stall=1, hold written.
  - Cycle 7: next A written. All A writes land in order.
- Register 0:
  - wbValid, wbAdr=0 → regWrite=0, stall=0.
  - mdValid, mdAdr=0 → mdReady=1, regWrite=0.
  - issueAdr=0 → busy[0]=0.
- Simultaneous set/clear: issueValid, issueAdr=7 in the same cycle as B transfer to adr 7 → busy[7]=1 afterward.
